ysyx_22040237_regfile: RTL and testbench

- Integer register file for the single-cycle core; the receiving end of the writeback interface (rd_wr_en/rd_idx/rd_data).
- Provides two combinational read ports to decode/execute, with same-cycle write-to-read bypass.
- Holds a pending-write scoreboard, set at issue and cleared at writeback; raises stall_o on RAW/WAW hazards so the same block serves a later multi-cycle or pipelined core.

---
 rtl/ysyx_22040237_regfile_pkg.sv | 29 ++
 rtl/ysyx_22040237_scoreboard.sv | 66 ++++++
 rtl/ysyx_22040237_regfile.sv | 86 ++++++++
 tb/tb_ysyx_22040237_regfile.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040237_regfile_pkg.sv
// Shared register-file constants and helpers for the ysyx_22040237 core.
// The width macros are kept for files that still use the define form.
`ifndef YSYX_22040237_REGFILE_DEFINES
`define YSYX_22040237_REGFILE_DEFINES
`define ysyx_22040237_REG_WIDTH 64
`define ysyx_22040237_REG_IDX_W 5
`define ysyx_22040237_NUM_GPR 32
`define ysyx_22040237_GPR_ZERO 0
`endif

package ysyx_22040237_regfile_pkg;

  localparam int REG_WIDTH = `ysyx_22040237_REG_WIDTH;
  localparam int REG_IDX_W = `ysyx_22040237_REG_IDX_W;
  localparam int NUM_GPR   = `ysyx_22040237_NUM_GPR;
  localparam int GPR_ZERO  = `ysyx_22040237_GPR_ZERO;

  // Individual hazard sources; stall is the OR of all of them.
  typedef struct packed {
    logic rs1_raw;
    logic rs2_raw;
    logic waw;
  } sb_hazard_t;

  function automatic logic is_zero_idx(input logic [REG_IDX_W-1:0] idx);
    return idx == REG_IDX_W'(GPR_ZERO);
  endfunction

endpackage

// File: rtl/ysyx_22040237_scoreboard.sv
// Pending-write scoreboard: marks destinations at issue, clears at writeback,
// and reports RAW/WAW hazards to decode.
module ysyx_22040237_scoreboard
  import ysyx_22040237_regfile_pkg::*;
#(
  parameter int IDX_W = REG_IDX_W,
  parameter int NREG  = NUM_GPR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wb_en,
  input  logic [IDX_W-1:0] i_wb_idx,
  input  logic [IDX_W-1:0] i_rs1_idx,
  input  logic [IDX_W-1:0] i_rs2_idx,
  input  logic             i_rs1_use,
  input  logic             i_rs2_use,
  input  logic             i_issue_en,
  input  logic [IDX_W-1:0] i_issue_idx,
  output logic             o_rs1_busy,
  output logic             o_rs2_busy,
  output logic             o_stall
);

  logic [NREG-1:1] r_pending;
  logic [NREG-1:1] w_pending_next;
  logic [NREG-1:1] w_clear_hit;
  logic [NREG-1:1] w_set_hit;
  logic [NREG-1:0] w_pend_full;
  logic            w_accept;
  sb_hazard_t      w_haz;

  // x0 is never pending, so bit 0 of the lookup vector is tied low.
  assign w_pend_full = {r_pending, 1'b0};

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_pend
      assign w_clear_hit[gi]    = i_wb_en && (i_wb_idx == IDX_W'(gi));
      assign w_set_hit[gi]      = w_accept && (i_issue_idx == IDX_W'(gi));
      // A new producer issued in the writeback cycle keeps ownership.
      assign w_pending_next[gi] = w_set_hit[gi] || (r_pending[gi] && !w_clear_hit[gi]);
    end
  endgenerate

  assign o_rs1_busy = rst && w_pend_full[i_rs1_idx]
                      && !(i_wb_en && (i_wb_idx == i_rs1_idx));
  assign o_rs2_busy = rst && w_pend_full[i_rs2_idx]
                      && !(i_wb_en && (i_wb_idx == i_rs2_idx));

  assign w_haz.rs1_raw = i_rs1_use && o_rs1_busy;
  assign w_haz.rs2_raw = i_rs2_use && o_rs2_busy;
  assign w_haz.waw     = rst && i_issue_en && w_pend_full[i_issue_idx]
                         && !(i_wb_en && (i_wb_idx == i_issue_idx));

  assign o_stall  = |w_haz;
  assign w_accept = rst && i_issue_en && !o_stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_next;
    end
  end

endmodule

// File: rtl/ysyx_22040237_regfile.sv
// Integer register file: x1..x31 storage, two combinational read ports with
// writeback bypass, and the pending-write scoreboard for issue control.
module ysyx_22040237_regfile
  import ysyx_22040237_regfile_pkg::*;
#(
  parameter int DATA_W = REG_WIDTH,
  parameter int IDX_W  = REG_IDX_W,
  parameter int NREG   = NUM_GPR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_wr_en_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic [IDX_W-1:0]  rs1_idx_i,
  input  logic [IDX_W-1:0]  rs2_idx_i,
  input  logic              rs1_use_i,
  input  logic              rs2_use_i,
  output logic [DATA_W-1:0] rs1_data_o,
  output logic [DATA_W-1:0] rs2_data_o,
  input  logic              issue_en_i,
  input  logic [IDX_W-1:0]  issue_rd_idx_i,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o,
  output logic              stall_o
);

  logic [DATA_W-1:0] r_regs    [1:NREG-1];
  logic [DATA_W-1:0] w_rd_view [NREG];
  logic [NREG-1:1]   w_wr_sel;
  logic              w_rs1_byp;
  logic              w_rs2_byp;

  assign w_rd_view[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_gpr
      assign w_wr_sel[gi]  = rd_wr_en_i && (rd_idx_i == IDX_W'(gi));
      assign w_rd_view[gi] = r_regs[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 1; i < NREG; i++) begin
      if (!rst) begin
        r_regs[i] <= '0;
      end else if (w_wr_sel[i]) begin
        r_regs[i] <= rd_data_i;
      end
    end
  end

  assign w_rs1_byp = rd_wr_en_i && (rd_idx_i == rs1_idx_i) && !is_zero_idx(rs1_idx_i);
  assign w_rs2_byp = rd_wr_en_i && (rd_idx_i == rs2_idx_i) && !is_zero_idx(rs2_idx_i);

  // Reads are forced to zero while reset is held, regardless of storage.
  always_comb begin
    rs1_data_o = '0;
    rs2_data_o = '0;
    if (rst) begin
      rs1_data_o = w_rs1_byp ? rd_data_i : w_rd_view[rs1_idx_i];
      rs2_data_o = w_rs2_byp ? rd_data_i : w_rd_view[rs2_idx_i];
    end
  end

  ysyx_22040237_scoreboard #(
    .IDX_W (IDX_W),
    .NREG  (NREG)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .i_wb_en     (rd_wr_en_i),
    .i_wb_idx    (rd_idx_i),
    .i_rs1_idx   (rs1_idx_i),
    .i_rs2_idx   (rs2_idx_i),
    .i_rs1_use   (rs1_use_i),
    .i_rs2_use   (rs2_use_i),
    .i_issue_en  (issue_en_i),
    .i_issue_idx (issue_rd_idx_i),
    .o_rs1_busy  (rs1_busy_o),
    .o_rs2_busy  (rs2_busy_o),
    .o_stall     (stall_o)
  );

endmodule

// File: tb/tb_ysyx_22040237_regfile.sv
// Bench for ysyx_22040237_regfile: directed vector table, then random traffic
// checked against an array/bit-map reference of the register file rules.
module tb_ysyx_22040237_regfile;

  localparam int DW = 64;
  localparam int IW = 5;
  localparam int NR = 32;
  localparam logic [DW-1:0] Z    = '0;
  localparam logic [DW-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [DW-1:0] V5   = 64'h1234_5678_9ABC_DEF0;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rd_wr_en_i = 1'b0;
  logic [IW-1:0] rd_idx_i = '0;
  logic [DW-1:0] rd_data_i = '0;
  logic [IW-1:0] rs1_idx_i = '0;
  logic [IW-1:0] rs2_idx_i = '0;
  logic          rs1_use_i = 1'b0;
  logic          rs2_use_i = 1'b0;
  logic [DW-1:0] rs1_data_o;
  logic [DW-1:0] rs2_data_o;
  logic          issue_en_i = 1'b0;
  logic [IW-1:0] issue_rd_idx_i = '0;
  logic          rs1_busy_o;
  logic          rs2_busy_o;
  logic          stall_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ysyx_22040237_regfile dut (
    .clk            (clk),
    .rst            (rst),
    .rd_wr_en_i     (rd_wr_en_i),
    .rd_idx_i       (rd_idx_i),
    .rd_data_i      (rd_data_i),
    .rs1_idx_i      (rs1_idx_i),
    .rs2_idx_i      (rs2_idx_i),
    .rs1_use_i      (rs1_use_i),
    .rs2_use_i      (rs2_use_i),
    .rs1_data_o     (rs1_data_o),
    .rs2_data_o     (rs2_data_o),
    .issue_en_i     (issue_en_i),
    .issue_rd_idx_i (issue_rd_idx_i),
    .rs1_busy_o     (rs1_busy_o),
    .rs2_busy_o     (rs2_busy_o),
    .stall_o        (stall_o)
  );

  typedef struct {
    bit            rst;
    bit            wr;
    logic [IW-1:0] rd;
    logic [DW-1:0] wd;
    logic [IW-1:0] r1;
    logic [IW-1:0] r2;
    bit            u1;
    bit            u2;
    bit            iss;
    logic [IW-1:0] ird;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
    bit            eb1;
    bit            eb2;
    bit            est;
  } vec_t;

  vec_t tbl[$];

  // Reference state: architectural values and the set of pending destinations.
  logic [DW-1:0] m_regs [NR];
  bit            m_pend [NR];

  function automatic vec_t mk(int rs, int wr, int rd, logic [DW-1:0] wd,
                              int r1, int r2, int u1, int u2, int iss, int ird,
                              logic [DW-1:0] e1, logic [DW-1:0] e2,
                              int eb1, int eb2, int est);
    vec_t v;
    v.rst = bit'(rs);   v.wr = bit'(wr);   v.rd = IW'(rd);   v.wd = wd;
    v.r1 = IW'(r1);     v.r2 = IW'(r2);    v.u1 = bit'(u1);  v.u2 = bit'(u2);
    v.iss = bit'(iss);  v.ird = IW'(ird);  v.e1 = e1;        v.e2 = e2;
    v.eb1 = bit'(eb1);  v.eb2 = bit'(eb2); v.est = bit'(est);
    return v;
  endfunction

  function automatic logic [DW-1:0] m_read(logic [IW-1:0] idx);
    if (!rst || idx == 0) return Z;
    if (rd_wr_en_i && rd_idx_i == idx) return rd_data_i;
    return m_regs[idx];
  endfunction

  function automatic bit m_busy(logic [IW-1:0] idx);
    return rst && m_pend[idx] && !(rd_wr_en_i && rd_idx_i == idx);
  endfunction

  function automatic bit m_stall();
    bit waw;
    waw = issue_en_i && m_pend[issue_rd_idx_i] && !(rd_wr_en_i && rd_idx_i == issue_rd_idx_i);
    return rst && ((rs1_use_i && m_busy(rs1_idx_i)) || (rs2_use_i && m_busy(rs2_idx_i)) || waw);
  endfunction

  // Applies the edge just taken; inputs are still those of the finished cycle.
  task automatic m_update(input bit st);
    if (!rst) begin
      for (int i = 0; i < NR; i++) begin
        m_regs[i] = Z;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (rd_wr_en_i && rd_idx_i != 0) m_regs[rd_idx_i] = rd_data_i;
      if (rd_wr_en_i) m_pend[rd_idx_i] = 1'b0;
      if (issue_en_i && !st && issue_rd_idx_i != 0) m_pend[issue_rd_idx_i] = 1'b1;
    end
  endtask

  task automatic chk(input string nm, input int id, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s #%0d: got %h, expected %h", nm, id, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input bit use_tbl, input int id);
    logic [DW-1:0] x1, x2;
    bit xb1, xb2, xst, st_now;
    string pfx;
    rst = v.rst;           rd_wr_en_i = v.wr;  rd_idx_i = v.rd;  rd_data_i = v.wd;
    rs1_idx_i = v.r1;      rs2_idx_i = v.r2;   rs1_use_i = v.u1; rs2_use_i = v.u2;
    issue_en_i = v.iss;    issue_rd_idx_i = v.ird;
    #2;
    st_now = m_stall();
    if (use_tbl) begin
      pfx = "tbl";
      x1 = v.e1; x2 = v.e2; xb1 = v.eb1; xb2 = v.eb2; xst = v.est;
    end else begin
      pfx = "rnd";
      x1 = m_read(rs1_idx_i); x2 = m_read(rs2_idx_i);
      xb1 = m_busy(rs1_idx_i); xb2 = m_busy(rs2_idx_i); xst = st_now;
    end
    chk({pfx, ".rs1_data"}, id, rs1_data_o, x1);
    chk({pfx, ".rs2_data"}, id, rs2_data_o, x2);
    chk({pfx, ".rs1_busy"}, id, DW'(rs1_busy_o), DW'(xb1));
    chk({pfx, ".rs2_busy"}, id, DW'(rs2_busy_o), DW'(xb2));
    chk({pfx, ".stall"},    id, DW'(stall_o),    DW'(xst));
    $display("%s %0d rst=%0b wr=%0b rd=%0d r1=%0d r2=%0d iss=%0b ird=%0d -> d1=%h d2=%h busy=%0b%0b stall=%0b errs=%0d",
             pfx, id, rst, rd_wr_en_i, rd_idx_i, rs1_idx_i, rs2_idx_i, issue_en_i,
             issue_rd_idx_i, rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o, stall_o, n_errors);
    @(posedge clk);
    m_update(st_now);
    #1;
  endtask

  function automatic logic [IW-1:0] rnd_idx();
    if ($urandom_range(0, 3) == 0) return IW'($urandom_range(0, NR - 1));
    return IW'($urandom_range(0, 7));
  endfunction

  initial begin
    vec_t rv;
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = Z;
      m_pend[i] = 1'b0;
    end

    // args: rst wr rd wdata | r1 r2 u1 u2 iss ird | e1 e2 busy1 busy2 stall
    tbl.push_back(mk(0, 0, 0, Z,          0, 0, 0, 0, 0, 0,  Z, Z, 0, 0, 0));
    for (int i = 1; i < NR; i++)
      tbl.push_back(mk(1, 1, i, ONES,     i, 0, 1, 0, 0, 0,  ONES, Z, 0, 0, 0));
    tbl.push_back(mk(0, 1, 5, V5,         5, 31, 1, 1, 1, 4, Z, Z, 0, 0, 0));
    for (int i = 1; i < NR; i++)
      tbl.push_back(mk(1, 0, 0, Z,        i, NR - i, 1, 1, 0, 0, Z, Z, 0, 0, 0));
    // Same-cycle bypass, then the stored value.
    tbl.push_back(mk(1, 1, 5, V5,         5, 0, 1, 0, 0, 0,  V5, Z, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, Z,          5, 5, 1, 1, 0, 0,  V5, V5, 0, 0, 0));
    // x0: write dropped, issue never marks it pending.
    tbl.push_back(mk(1, 1, 0, 64'hDEAD,   0, 0, 1, 1, 0, 0,  Z, Z, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, Z,          0, 0, 1, 1, 1, 0,  Z, Z, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, Z,          0, 0, 1, 1, 1, 0,  Z, Z, 0, 0, 0));
    // RAW on x7 resolved by a writeback in the same cycle.
    tbl.push_back(mk(1, 0, 0, Z,          0, 0, 0, 0, 1, 7,  Z, Z, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, Z,          7, 5, 1, 1, 0, 0,  Z, V5, 1, 0, 1));
    tbl.push_back(mk(1, 1, 7, 64'h42,     7, 7, 1, 0, 0, 0,  64'h42, 64'h42, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, Z,          7, 7, 1, 1, 0, 0,  64'h42, 64'h42, 0, 0, 0));
    // WAW on x3; re-issue alongside writeback keeps x3 pending.
    tbl.push_back(mk(1, 0, 0, Z,          0, 0, 0, 0, 1, 3,  Z, Z, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, Z,          3, 0, 0, 0, 1, 3,  Z, Z, 1, 0, 1));
    tbl.push_back(mk(1, 1, 3, 64'h33,     3, 0, 0, 0, 1, 3,  64'h33, Z, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, Z,          3, 3, 0, 1, 0, 0,  64'h33, 64'h33, 1, 1, 1));
    tbl.push_back(mk(1, 1, 3, 64'h34,     0, 3, 0, 1, 0, 0,  Z, 64'h34, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, Z,          3, 0, 1, 0, 0, 0,  64'h34, Z, 0, 0, 0));
    // Mid-sequence reset discards pending x1/x2 and written x9.
    tbl.push_back(mk(1, 0, 0, Z,          0, 0, 0, 0, 1, 1,  Z, Z, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, Z,          0, 0, 0, 0, 1, 2,  Z, Z, 0, 0, 0));
    tbl.push_back(mk(1, 1, 9, 64'h99,     9, 1, 0, 1, 0, 0,  64'h99, Z, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 64'h77,     1, 9, 1, 1, 1, 1,  Z, Z, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, Z,          1, 9, 1, 1, 1, 1,  Z, Z, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, Z,          1, 2, 1, 1, 0, 0,  Z, Z, 1, 0, 1));
    tbl.push_back(mk(1, 1, 1, 64'h5,      1, 2, 1, 1, 0, 0,  64'h5, Z, 0, 0, 0));

    foreach (tbl[i]) step(tbl[i], 1'b1, i);

    for (int n = 0; n < 800; n++) begin
      rv = mk(($urandom_range(0, 63) != 0) ? 1 : 0, int'($urandom_range(0, 1)),
              int'(rnd_idx()), {$urandom, $urandom},
              int'(rnd_idx()), int'(rnd_idx()),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 1)), int'(rnd_idx()),
              Z, Z, 0, 0, 0);
      step(rv, 1'b0, n);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
